// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: holds the PLL in reset and writes the M/N high/low counts
// into an Altera-style reconfiguration core. It then pulses reconfig, releases
// the PLL and qualifies its lock into pll_locked / pll_stable. It also
// supervises lock timeout and lock loss. Every output is a flop.
module pll_reconfig_seq #(
    parameter int         RST_CYCLES    = 16,
    parameter int         STABLE_CYCLES = 1024,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         CNT_WIDTH     = 16,
    parameter logic [3:0] M_TYPE        = 4'h1,
    parameter logic [3:0] N_TYPE        = 4'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pll_reset,
    input  logic [15:0] pll_data,
    input  logic        pll_trigger,
    output logic        pll_locked,
    output logic        pll_stable,
    output logic        pll_error,
    output logic        busy,
    output logic [3:0]  rc_counter_type,
    output logic [2:0]  rc_counter_param,
    output logic [8:0]  rc_data_in,
    output logic        rc_write_param,
    output logic        rc_reconfig,
    input  logic        rc_busy,
    output logic        pll_areset,
    input  logic        pll_locked_raw
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_HOLD_RST, ST_WRITE, ST_WAIT_WR, ST_RECONFIG, ST_WAIT_RC,
        ST_RELEASE, ST_WAIT_LOCK, ST_STABLE_CNT, ST_RUN, ST_ERROR
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RST_LAST    = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(LOCK_TIMEOUT);
    // The write strobe is visible in the first WAIT_WR cycle, and the core raises
    // busy one cycle late. So rc_busy is trusted only from the third WAIT_WR cycle.
    localparam logic [CNT_WIDTH-1:0] WR_BLANK    = CNT_WIDTH'(2);
    // The reconfig strobe is visible in the RECONFIG cycle, so only the first
    // WAIT_RC cycle is blanked.
    localparam logic [CNT_WIDTH-1:0] RC_BLANK    = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]             idx_q, idx_d;
    logic [7:0]             m_q, m_d, n_q, n_d;
    logic                   lock_s1_q, lock_s1_d, lock_s2_q, lock_s2_d;
    logic                   areset_q, areset_d, locked_q, locked_d, stable_q, stable_d;
    logic                   error_q, error_d, busy_q, busy_d, wr_q, wr_d, rcfg_q, rcfg_d;
    logic [3:0]             type_q, type_d;
    logic [2:0]             param_q, param_d;
    logic [8:0]             data_q, data_d;
    logic                   mn_ok;
    logic [7:0]             wr_val;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // High count of a divide: (v+1)>>1, computed in 9 bits so v=255 gives 128.
    function automatic logic [8:0] half_up(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + 9'd1;
        return {1'b0, s[8:1]};
    endfunction

    function automatic logic [8:0] half_dn(input logic [7:0] v);
        return {2'b00, v[7:1]};
    endfunction

    // Next-state, counter and registered-output computation; pll_reset overrides all.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        m_d       = m_q;
        n_d       = n_q;
        lock_s1_d = pll_locked_raw;
        lock_s2_d = lock_s1_q;
        wr_d      = 1'b0;
        rcfg_d    = 1'b0;
        type_d    = 4'h0;
        param_d   = 3'b000;
        data_d    = 9'd0;
        mn_ok     = (pll_data[15:8] >= 8'd2) && (pll_data[7:0] >= 8'd2);
        wr_val    = idx_q[1] ? n_q : m_q;

        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (pll_trigger) begin
                    m_d     = pll_data[15:8];
                    n_d     = pll_data[7:0];
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    state_d = mn_ok ? ST_HOLD_RST : ST_ERROR;
                end
            end
            ST_HOLD_RST: begin
                if (cnt_q >= RST_LAST) begin
                    state_d = ST_WRITE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_WRITE: begin
                if (!rc_busy) begin
                    state_d = ST_WAIT_WR;
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    type_d  = idx_q[1] ? N_TYPE : M_TYPE;
                    param_d = {2'b00, idx_q[0]};
                    data_d  = idx_q[0] ? half_dn(wr_val) : half_up(wr_val);
                end
            end
            ST_WAIT_WR: begin
                if (cnt_q < WR_BLANK) begin
                    cnt_d = sat_inc(cnt_q);
                end else if (!rc_busy) begin
                    if (idx_q == 2'd3) begin
                        state_d = ST_RECONFIG;
                        rcfg_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_RECONFIG: begin
                state_d = ST_WAIT_RC;
                cnt_d   = '0;
            end
            ST_WAIT_RC: begin
                if (cnt_q < RC_BLANK) begin
                    cnt_d = sat_inc(cnt_q);
                end else if (!rc_busy) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_WAIT_LOCK: begin
                if (lock_s2_q) begin
                    state_d = ST_STABLE_CNT;
                    cnt_d   = '0;
                end else if (cnt_q >= TIMEOUT_LIM) begin
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_STABLE_CNT: begin
                if (!lock_s2_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_RUN: begin
                // A new request takes precedence; the PLL is reset again anyway.
                if (pll_trigger) begin
                    m_d     = pll_data[15:8];
                    n_d     = pll_data[7:0];
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    state_d = mn_ok ? ST_HOLD_RST : ST_ERROR;
                end else if (!lock_s2_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pll_reset) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            idx_d     = 2'd0;
            lock_s1_d = 1'b0;
            lock_s2_d = 1'b0;
            wr_d      = 1'b0;
            rcfg_d    = 1'b0;
            type_d    = 4'h0;
            param_d   = 3'b000;
            data_d    = 9'd0;
        end

        // Level outputs follow the state being entered, so they change with it.
        areset_d = !(state_d inside {ST_RELEASE, ST_WAIT_LOCK, ST_STABLE_CNT, ST_RUN});
        locked_d = (state_d inside {ST_STABLE_CNT, ST_RUN});
        stable_d = (state_d == ST_RUN);
        error_d  = (state_d == ST_ERROR);
        busy_d   = !(state_d inside {ST_IDLE, ST_RUN, ST_ERROR});
    end

    // State, counter, lock synchronizer and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            m_q       <= 8'd0;
            n_q       <= 8'd0;
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
            areset_q  <= 1'b1;
            locked_q  <= 1'b0;
            stable_q  <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            rcfg_q    <= 1'b0;
            type_q    <= 4'h0;
            param_q   <= 3'b000;
            data_q    <= 9'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            m_q       <= m_d;
            n_q       <= n_d;
            lock_s1_q <= lock_s1_d;
            lock_s2_q <= lock_s2_d;
            areset_q  <= areset_d;
            locked_q  <= locked_d;
            stable_q  <= stable_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            rcfg_q    <= rcfg_d;
            type_q    <= type_d;
            param_q   <= param_d;
            data_q    <= data_d;
        end
    end

    assign pll_areset       = areset_q;
    assign pll_locked       = locked_q;
    assign pll_stable       = stable_q;
    assign pll_error        = error_q;
    assign busy             = busy_q;
    assign rc_write_param   = wr_q;
    assign rc_reconfig      = rcfg_q;
    assign rc_counter_type  = type_q;
    assign rc_counter_param = param_q;
    assign rc_data_in       = data_q;

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Sequencer between the stimulus engine's PLL control outputs (pll_reset, pll_data, pll_trigger) and an Altera-style PLL reconfiguration core plus the PLL's raw lock output.
- On a trigger it holds the PLL in reset and writes M/N counter high/low parameters. It then pulses reconfig, releases reset, and qualifies lock into pll_locked / pll_stable for the stimulus engine.
- Also supervises lock loss and timeouts.

Parameters:
- RST_CYCLES, 16: cycles pll_areset is held before the first parameter write.
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before pll_stable.
- LOCK_TIMEOUT, 65535: maximum cycles in WAIT_LOCK before error.
- CNT_WIDTH, 16: width of the internal cycle counter. Must hold max(RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT).
- M_TYPE, 4'h1: rc_counter_type code for the M counter.
- N_TYPE, 4'h0: rc_counter_type code for the N counter.

Ports:
- clock  in  1: system clock; all logic in this domain.
- reset_n  in  1: asynchronous active-low reset.
- pll_reset  in  1: level request from stim. While high, the block forces pll_areset and returns to IDLE.
- pll_data  in  16: [15:8] = M, [7:0] = N; sampled on trigger.
- pll_trigger  in  1: single-cycle reconfigure request.
- pll_locked  out  1: synchronized PLL lock, qualified by state.
- pll_stable  out  1: lock held STABLE_CYCLES.
- pll_error  out  1: sticky fault; cleared by the next accepted trigger or by pll_reset.
- busy  out  1: high in every state except IDLE, RUN and ERROR.
- rc_counter_type  out  4: parameter write target.
- rc_counter_param  out  3: 3'b000 = high count, 3'b001 = low count.
- rc_data_in  out  9: parameter value, zero-extended.
- rc_write_param  out  1: one-cycle write strobe.
- rc_reconfig  out  1: one-cycle reconfig strobe.
- rc_busy  in  1: reconfig core busy.
- pll_areset  out  1: PLL asynchronous reset.
- pll_locked_raw  in  1: asynchronous lock from the PLL; 2-flop synchronized internally.

Behaviour:
- Reset (and whenever pll_reset=1):
  - state=IDLE, pll_areset=1, all other outputs 0, counter cleared, synchronizer cleared.
  - pll_reset has priority over every event, including a simultaneous trigger.
- IDLE:
  - pll_areset=1.
  - pll_trigger=1 latches M/N and clears pll_error.
  - If M<2 or N<2: go to ERROR (pll_error=1 the next cycle). Otherwise go to HOLD_RST.
- HOLD_RST: counts RST_CYCLES cycles, then goes to WRITE with write index=0.
- WRITE / WAIT_WR:
  - Four writes in order: (M_TYPE, high, (M+1)>>1), (M_TYPE, low, M>>1), (N_TYPE, high, (N+1)>>1), (N_TYPE, low, N>>1).
  - WRITE issues rc_write_param for one cycle, with type/param/data valid that cycle, only when rc_busy=0. If rc_busy=1 it waits in WRITE.
  - WAIT_WR waits for rc_busy=0, then advances the index. After the 4th write it goes to RECONFIG.
  - rc_busy must be ignored in the cycle directly after a strobe; the core raises busy one cycle late.
- RECONFIG: rc_reconfig=1 for one cycle, then WAIT_RC.
- WAIT_RC: waits for rc_busy=0 (same one-cycle blanking rule), then RELEASE.
- RELEASE: pll_areset=0 from this state onward; clears the counter; goes to WAIT_LOCK.
- WAIT_LOCK:
  - Synchronized lock=1 → STABLE_CNT.
  - Counter reaching LOCK_TIMEOUT → ERROR.
- STABLE_CNT:
  - pll_locked=1.
  - Counter counts consecutive locked cycles; a lock drop clears it and returns to WAIT_LOCK.
  - After STABLE_CYCLES → RUN.
- RUN:
  - pll_locked=1, pll_stable=1.
  - Lock drop → WAIT_LOCK with pll_stable=0 the next cycle (lock-loss re-qualification).
  - pll_trigger → HOLD_RST (reconfigure) with pll_areset=1 the next cycle.
- ERROR:
  - pll_error=1, pll_areset=1.
  - A trigger behaves as in IDLE.
- Trigger while busy=1 is ignored; no queuing.
- Counter saturates and never wraps.
- Any transition to IDLE/ERROR drops pll_locked and pll_stable in the same cycle as the state change.
- Lock latency: pll_locked rises 2 cycles (synchronizer) + 1 cycle after pll_locked_raw rises.

Test Plan:
- Normal run:
  - Stimulus: trigger with pll_data=16'h0A02; rc_busy high 3 cycles per op; pll_locked_raw rises 100 cycles after pll_areset falls.
  - Required: writes (1,0,5), (1,1,5), (0,0,1), (0,1,1); one rc_reconfig; pll_locked 3 cycles after raw lock; pll_stable STABLE_CYCLES cycles later; busy=0 in RUN.
- Odd divide:
  - Stimulus: pll_data=16'h0703.
  - Required: M writes high 4, low 3; N writes high 2, low 1.
- Rejection:
  - Stimulus: pll_data=16'h0105.
  - Required: ERROR, pll_error=1, no rc_write_param issued.
  - Then trigger 16'h0404: pll_error clears and the sequence completes.
- Timeout:
  - Stimulus: lock never asserts, LOCK_TIMEOUT=200.
  - Required: pll_error=1 about 200 cycles after RELEASE; pll_areset=1.
- Lock loss:
  - Stimulus: in RUN, drop pll_locked_raw for 10 cycles.
  - Required: pll_stable falls; full STABLE_CYCLES re-count after re-lock; no new writes.
- Reset mid-operation:
  - Stimulus: assert pll_reset during the 2nd write; separately, assert reset_n=0 during WAIT_RC.
  - Required: both return to IDLE immediately with pll_areset=1 and strobes 0; a trigger in the same cycle as pll_reset is ignored.
